// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pkg
//  Purpose  : Shared fixed-point types, FSM state encoding and the output
//             shift / ReLU / clamp helper for the fully-connected layer engine.
//  Revision : 1.0  initial release
// ============================================================================
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_ACC_WIDTH  = 40;
    localparam int FRAC_BITS     = 8;

    // Clamp limits of a DATA_WIDTH signed word
    localparam int WORD_MAX = (2 ** (NN_DATA_WIDTH - 1)) - 1;
    localparam int WORD_MIN = -(2 ** (NN_DATA_WIDTH - 1));

    typedef logic signed [NN_DATA_WIDTH-1:0]   word_t;
    typedef logic signed [2*NN_DATA_WIDTH-1:0] prod_t;
    typedef logic signed [NN_ACC_WIDTH-1:0]    acc_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Rescale the accumulator back to a word: floor shift, optional ReLU, clamp
    function automatic word_t sat_word(input acc_t acc, input logic relu);
        acc_t r;
        r = acc >>> FRAC_BITS;
        if (relu && (r < 0)) begin
            r = '0;
        end
        if (r > acc_t'(WORD_MAX)) begin
            sat_word = word_t'(WORD_MAX);
        end else if (r < acc_t'(WORD_MIN)) begin
            sat_word = word_t'(WORD_MIN);
        end else begin
            sat_word = r[NN_DATA_WIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pipe
//  Purpose  : Two-stage multiply/accumulate. Stage 1 registers the signed
//             product of the RAM read data, stage 2 adds it into the
//             accumulator. A bias load re-seeds the accumulator for a new
//             neuron; the sequencer guarantees it never meets a valid product.
//  Revision : 1.0  initial release
// ============================================================================
module mac_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    input  logic                         i_load_bias,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    output logic signed [ACC_WIDTH-1:0]  o_acc
);

    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic                           r_pvalid;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_bias_ext;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;

    assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){i_bias[DATA_WIDTH-1]}}, i_bias};
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){r_prod[2*DATA_WIDTH-1]}}, r_prod};

    // Stage 1: register the product of the incoming read data and its valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= '0;
            r_pvalid <= 1'b0;
        end else begin
            r_prod   <= i_x * i_w;
            r_pvalid <= i_valid;
        end
    end

    // Stage 2: bias seeds the accumulator in Q.FRAC alignment, products add in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load_bias) begin
            r_acc <= w_bias_ext <<< FRAC_BITS;
        end else if (r_pvalid) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/layer_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : layer_mac_seq
//  Purpose  : Evaluates one fully-connected layer. Walks the activation,
//             weight and bias RAMs (1-cycle registered reads), accumulates
//             each neuron's dot product plus bias, and writes the rescaled,
//             optionally rectified and saturated result to the next layer's
//             activation RAM.
//  Revision : 1.0  initial release
// ============================================================================
module layer_mac_seq
    import nn_pkg::*;
#(
    parameter int N_INPUTS   = 784,
    parameter int N_NEURONS  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int X_AW       = 10,
    parameter int W_AW       = 13,
    parameter int N_AW       = 4,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [X_AW-1:0]       x_addr,
    input  logic [DATA_WIDTH-1:0] x_q,
    output logic [W_AW-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] w_q,
    output logic [N_AW-1:0]       b_addr,
    input  logic [DATA_WIDTH-1:0] b_q,
    output logic                  y_we,
    output logic [N_AW-1:0]       y_addr,
    output logic [DATA_WIDTH-1:0] y_d
);

    localparam logic [X_AW-1:0] c_LAST_I = X_AW'(N_INPUTS - 1);
    localparam logic [N_AW-1:0] c_LAST_J = N_AW'(N_NEURONS - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic   [X_AW-1:0]            r_i;          // input index, doubles as x_addr
    logic   [N_AW-1:0]            r_j;          // neuron index, doubles as b_addr/y_addr
    logic   [W_AW-1:0]            r_w_addr;     // running weight counter
    logic                         r_drain;      // second DRAIN cycle marker
    logic                         r_rd_valid;   // RAM read data valid this cycle
    logic   [DATA_WIDTH-1:0]      r_y_hold;     // last written result word
    logic                         w_load_bias;
    logic signed [ACC_WIDTH-1:0]  w_acc;
    logic   [DATA_WIDTH-1:0]      w_y_sat;

    // The bias read issued in BIAS returns in the first MAC cycle (i == 0)
    assign w_load_bias = (r_state == S_MAC) && (r_i == '0);
    assign w_y_sat     = DATA_WIDTH'(sat_word(acc_t'(w_acc), RELU != 0));

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (r_rd_valid),
        .i_load_bias (w_load_bias),
        .i_x         (x_q),
        .i_w         (w_q),
        .i_bias      (b_q),
        .o_acc       (w_acc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        y_we        = 1'b0;
        y_d         = r_y_hold;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_BIAS;
                end
            end
            S_BIAS: begin
                busy        = 1'b1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (r_i == c_LAST_I) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                y_we = 1'b1;
                y_d  = w_y_sat;
                if (r_j == c_LAST_J) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BIAS;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address counters, drain marker, read-valid tracking and result hold.
    // The weight counter only ever steps by one: it holds on the last MAC
    // cycle so w_addr stays put, and takes the deferred step in the next
    // neuron's BIAS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_w_addr   <= '0;
            r_drain    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_y_hold   <= '0;
        end else begin
            r_rd_valid <= (r_state == S_MAC);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_j      <= '0;
                        r_w_addr <= '0;
                    end
                end
                S_BIAS: begin
                    r_i <= '0;
                    if (r_j != '0) begin
                        r_w_addr <= r_w_addr + W_AW'(1);
                    end
                end
                S_MAC: begin
                    r_drain <= 1'b0;
                    if (r_i != c_LAST_I) begin
                        r_i      <= r_i + X_AW'(1);
                        r_w_addr <= r_w_addr + W_AW'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= ~r_drain;
                end
                S_WRITE: begin
                    r_y_hold <= w_y_sat;
                    if (r_j != c_LAST_J) begin
                        r_j <= r_j + N_AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x_addr = r_i;
    assign w_addr = r_w_addr;
    assign b_addr = r_j;
    assign y_addr = r_j;

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_mac_seq
//  Purpose  : Scoreboard bench for layer_mac_seq (4 inputs, 2 neurons).
//             Two instances share the RAM contents: one with ReLU, one
//             without. Expected writes are queued at start; monitors pop
//             and compare on every y_we.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_mac_seq;

    localparam int NI = 4;
    localparam int NN = 2;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } exp_t;

    logic clk;
    logic rst_n;
    logic start;

    logic [15:0] xmem [0:1023];
    logic [15:0] wmem [0:8191];
    logic [15:0] bmem [0:15];

    // ReLU instance signals
    logic        busy_r, done_r, y_we_r;
    logic [9:0]  x_addr_r;
    logic [12:0] w_addr_r;
    logic [3:0]  b_addr_r, y_addr_r;
    logic [15:0] x_q_r, w_q_r, b_q_r, y_d_r;
    // Bypass instance signals
    logic        busy_n, done_n, y_we_n;
    logic [9:0]  x_addr_n;
    logic [12:0] w_addr_n;
    logic [3:0]  b_addr_n, y_addr_n;
    logic [15:0] x_q_n, w_q_n, b_q_n, y_d_n;

    exp_t q_r[$];
    exp_t q_n[$];
    int   n_cmp = 0;
    int   n_err = 0;

    layer_mac_seq #(
        .N_INPUTS (NI), .N_NEURONS (NN), .RELU (1)
    ) dut_r (
        .clk (clk), .rst_n (rst_n), .start (start),
        .busy (busy_r), .done (done_r),
        .x_addr (x_addr_r), .x_q (x_q_r),
        .w_addr (w_addr_r), .w_q (w_q_r),
        .b_addr (b_addr_r), .b_q (b_q_r),
        .y_we (y_we_r), .y_addr (y_addr_r), .y_d (y_d_r)
    );

    layer_mac_seq #(
        .N_INPUTS (NI), .N_NEURONS (NN), .RELU (0)
    ) dut_n (
        .clk (clk), .rst_n (rst_n), .start (start),
        .busy (busy_n), .done (done_n),
        .x_addr (x_addr_n), .x_q (x_q_n),
        .w_addr (w_addr_n), .w_q (w_q_n),
        .b_addr (b_addr_n), .b_q (b_q_n),
        .y_we (y_we_n), .y_addr (y_addr_n), .y_d (y_d_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal RAMs with 1-cycle registered read
    always @(posedge clk) begin
        x_q_r <= xmem[x_addr_r];
        w_q_r <= wmem[w_addr_r];
        b_q_r <= bmem[b_addr_r];
        x_q_n <= xmem[x_addr_n];
        w_q_n <= wmem[w_addr_n];
        b_q_n <= bmem[b_addr_n];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every write must match the head of the expectation queue
    always @(negedge clk) begin
        if (y_we_r) begin
            if (q_r.size() == 0) begin
                chk("we_r_unexpected_qsize", 64'(q_r.size()), 64'd1);
            end else begin
                exp_t e;
                e = q_r.pop_front();
                chk("y_addr_r", 64'(y_addr_r), 64'(e.a));
                chk("y_d_r", 64'(y_d_r), 64'(e.d));
            end
        end
    end

    always @(negedge clk) begin
        if (y_we_n) begin
            if (q_n.size() == 0) begin
                chk("we_n_unexpected_qsize", 64'(q_n.size()), 64'd1);
            end else begin
                exp_t e;
                e = q_n.pop_front();
                chk("y_addr_n", 64'(y_addr_n), 64'(e.a));
                chk("y_d_n", 64'(y_d_n), 64'(e.d));
            end
        end
    end

    // Vectors are given {elem3, elem2, elem1, elem0}
    task automatic load(input logic [3:0][15:0] xv, input logic [3:0][15:0] w0v,
                        input logic [3:0][15:0] w1v, input logic [15:0] b0,
                        input logic [15:0] b1);
        for (int i = 0; i < NI; i++) begin
            xmem[i]      = xv[i];
            wmem[i]      = w0v[i];
            wmem[NI + i] = w1v[i];
        end
        bmem[0] = b0;
        bmem[1] = b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_r"}, {busy_r, done_r, y_we_r, x_addr_r, w_addr_r, b_addr_r, y_addr_r, y_d_r}, 64'd0);
        chk({tag, "_n"}, {busy_n, done_n, y_we_n, x_addr_n, w_addr_n, b_addr_n, y_addr_n, y_d_n}, 64'd0);
    endtask

    // One run: start sampled at edge k, then 20 cycles observed.
    // p1/p2: cycles whose closing edge sees a stray start (0 = none).
    // rst_c: cycle at whose negedge rst_n drops for one cycle (0 = none).
    task automatic run(input logic [15:0] er0, input logic [15:0] er1,
                       input logic [15:0] en0, input logic [15:0] en1,
                       input int p1, input int p2, input int rst_c);
        logic eb, ed;
        q_r.push_back('{a: 4'd0, d: er0});
        q_n.push_back('{a: 4'd0, d: en0});
        if (rst_c == 0) begin
            q_r.push_back('{a: 4'd1, d: er1});
            q_n.push_back('{a: 4'd1, d: en1});
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rst_c != 0 && c > rst_c) begin
                eb = 1'b0;
                ed = 1'b0;
            end else begin
                eb = (c <= 16);
                ed = (c == 17);
            end
            chk("busy_r", 64'(busy_r), 64'(eb));
            chk("done_r", 64'(done_r), 64'(ed));
            chk("busy_n", 64'(busy_n), 64'(eb));
            chk("done_n", 64'(done_n), 64'(ed));
            if (rst_c == 0 || c <= rst_c) begin
                if (c >= 2 && c <= 5) begin
                    chk("w_addr_mac0", 64'(w_addr_r), 64'(c - 2));
                    chk("x_addr_mac0", 64'(x_addr_n), 64'(c - 2));
                end
                if (c >= 10 && c <= 13) begin
                    chk("w_addr_mac1", 64'(w_addr_r), 64'(c - 6));
                    chk("x_addr_mac1", 64'(x_addr_n), 64'(c - 10));
                end
            end
            start = (c == p1 || c == p2);
            if (rst_c != 0 && c == rst_c + 1) begin
                rst_n = 1'b1;
            end
            if (rst_c != 0 && c == rst_c) begin
                rst_n = 1'b0;
                #1 chk_zero("zero_after_async_rst");
            end
        end
        start = 1'b0;
        chk("queue_left_r", 64'(q_r.size()), 64'd0);
        chk("queue_left_n", 64'(q_n.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            xmem[i] = '0;
            wmem[i] = '0;
            bmem[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_state");

        // x = [1, 2, -1, 0.5]; w0 = +1, w1 = -1; no bias
        load({16'h0080, 16'hFF00, 16'h0200, 16'h0100},
             {16'h0100, 16'h0100, 16'h0100, 16'h0100},
             {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 16'h0000, 16'h0000);
        run(16'h0280, 16'h0000, 16'h0280, 16'hFD80, 0, 0, 0);

        // Saturation both directions
        load({16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00},
             {16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00},
             {16'h8100, 16'h8100, 16'h8100, 16'h8100}, 16'h0000, 16'h0000);
        run(16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000, 0, 0, 0);

        // Stray starts mid-run are ignored
        load({16'h0080, 16'hFF00, 16'h0200, 16'h0100},
             {16'h0100, 16'h0100, 16'h0100, 16'h0100},
             {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 16'h0000, 16'h0000);
        run(16'h0280, 16'h0000, 16'h0280, 16'hFD80, 5, 12, 0);

        // Bias pass-through and floor of a tiny negative product
        load({16'h0000, 16'h0000, 16'h0000, 16'h0001},
             {16'h0000, 16'h0000, 16'h0000, 16'h0000},
             {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h0180, 16'h0000);
        run(16'h0180, 16'h0000, 16'h0180, 16'hFFFF, 0, 0, 0);

        // Reset during MAC of neuron 1, then a clean rerun
        load({16'h0080, 16'hFF00, 16'h0200, 16'h0100},
             {16'h0100, 16'h0100, 16'h0100, 16'h0100},
             {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 16'h0000, 16'h0000);
        run(16'h0280, 16'h0000, 16'h0280, 16'h0000, 0, 0, 11);
        run(16'h0280, 16'h0000, 16'h0280, 16'hFD80, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
